// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the binary CNN window buffer.
// Optional build macro: CNN_WIN_ZEROPAD_EN ("same" padding scan).
package cnn_pkg;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_K     = 3;
    localparam int DEF_DIN_W = 8;
    localparam int DEF_PIX_W = 2;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    // Width of a counter/index covering 0..n-1, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int win_count(input int w, input int h, input int k, input bit pad);
        return pad ? (w * h) : ((w - k + 1) * (h - k + 1));
    endfunction

endpackage

// File: rtl/cnn_win_scan.sv
// Anchor counters and K*K read-address generation for the window scan.
// Optional build macro: CNN_WIN_ZEROPAD_EN (centre anchors, out-of-image mask).
module cnn_win_scan
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K,
    parameter int RW    = addr_w(IMG_H),
    parameter int CW    = addr_w(IMG_W),
    parameter int AW    = addr_w(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [RW-1:0]     row,
    output logic [CW-1:0]     col,
    output logic              last,
    output logic [K*K*AW-1:0] rd_addr,
    output logic [K*K-1:0]    rd_mask
);

`ifdef CNN_WIN_ZEROPAD_EN
    localparam int ROW_MAX = IMG_H - 1;
    localparam int COL_MAX = IMG_W - 1;
    localparam int OFF     = K / 2;
`else
    localparam int ROW_MAX = IMG_H - K;
    localparam int COL_MAX = IMG_W - K;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == CW'(COL_MAX)) begin
                col <= '0;
                row <= (row == RW'(ROW_MAX)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign last = (row == RW'(ROW_MAX)) && (col == CW'(COL_MAX));

    always_comb begin
        rd_addr = '0;
        rd_mask = '1;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
`ifdef CNN_WIN_ZEROPAD_EN
                int pr;
                int pc;
                pr = int'(row) + r - OFF;
                pc = int'(col) + c - OFF;
                // Taps falling outside the image read as zero.
                if (pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W)
                    rd_addr[(r*K+c)*AW +: AW] = AW'(pr * IMG_W + pc);
                else
                    rd_mask[r*K+c] = 1'b0;
`else
                rd_addr[(r*K+c)*AW +: AW] = AW'((int'(row) + r) * IMG_W + int'(col) + c);
`endif
            end
        end
    end

endmodule

// File: rtl/cnn_window_buffer.sv
// Binary frame store plus K x K sliding-window streamer with a skid output register.
// Optional build macro: CNN_WIN_ZEROPAD_EN ("same" padding, all anchors scanned).
module cnn_window_buffer
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K,
    parameter int DIN_W = DEF_DIN_W,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIN_W-1:0]           in_data,
    input  logic                       start,
    output logic                       frame_loaded,
    output logic                       busy,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [K*K*PIX_W-1:0]       win_data,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       win_last,
    output logic [1:0]                 dbg_state
);

    // Handshake: a window transfers on any rising edge with win_valid && win_ready;
    // while win_valid is high and win_ready low, every win_* output holds.
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = addr_w(N);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int KK = K * K;

    logic [1:0]          state;
    logic [AW-1:0]       wr_ptr;
    logic [N-1:0]        mem;
    logic                scan_done;
    logic                wr_en;
    logic                last_beat;
    logic                issue;
    logic [RW-1:0]       scan_row;
    logic [CW-1:0]       scan_col;
    logic                scan_last;
    logic [KK*AW-1:0]    rd_addr;
    logic [KK-1:0]       rd_mask;
    logic [KK*PIX_W-1:0] win_next;

    assign in_ready     = (state == ST_LOAD);
    assign frame_loaded = (state == ST_FULL) || (state == ST_SCAN);
    assign busy         = (state == ST_SCAN);
    assign dbg_state    = state;

    assign wr_en     = in_valid && in_ready;
    assign last_beat = ({1'b0, wr_ptr} + (AW+1)'(DIN_W)) == (AW+1)'(N);
    assign issue     = (state == ST_SCAN) && !scan_done && (!win_valid || win_ready);

    cnn_win_scan #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .RW    (RW),
        .CW    (CW),
        .AW    (AW)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_SCAN),
        .advance (issue),
        .row     (scan_row),
        .col     (scan_col),
        .last    (scan_last),
        .rd_addr (rd_addr),
        .rd_mask (rd_mask)
    );

    // Pixel array is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DIN_W; i++)
                mem[wr_ptr + AW'(i)] <= in_data[i];
        end
    end

    always_comb begin
        win_next = '0;
        for (int e = 0; e < KK; e++)
            win_next[e*PIX_W +: PIX_W] = {PIX_W{mem[rd_addr[e*AW +: AW]] & rd_mask[e]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            scan_done <= 1'b0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_last  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (wr_en) begin
                        if (last_beat) begin
                            state  <= ST_FULL;
                            wr_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(DIN_W);
                        end
                    end
                end
                ST_FULL: begin
                    if (start) begin
                        state     <= ST_SCAN;
                        scan_done <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (issue) begin
                        win_valid <= 1'b1;
                        win_data  <= win_next;
                        win_row   <= scan_row;
                        win_col   <= scan_col;
                        win_last  <= scan_last;
                        if (scan_last)
                            scan_done <= 1'b1;
                    end else if (win_valid && win_ready) begin
                        win_valid <= 1'b0;
                        win_last  <= 1'b0;
                        // Final window consumed: frame is released for reloading.
                        if (win_last) begin
                            state     <= ST_LOAD;
                            scan_done <= 1'b0;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_buffer.sv
// Scoreboard bench for cnn_window_buffer: directed frames, queued expected windows.
// Build with CNN_WIN_ZEROPAD_EN defined to exercise the "same" padding scan.
module tb_cnn_window_buffer;
    import cnn_pkg::*;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;
    localparam int DIN_W = 8;
    localparam int PIX_W = 2;
    localparam int N     = IMG_W * IMG_H;
    localparam int NB    = N / DIN_W;
    localparam int DW    = K * K * PIX_W;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int EW    = 1 + RW + CW + DW;
`ifdef CNN_WIN_ZEROPAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int OFF  = PAD ? K / 2 : 0;
    localparam int RMAX = PAD ? IMG_H - 1 : IMG_H - K;
    localparam int CMAX = PAD ? IMG_W - 1 : IMG_W - K;
    localparam int NWIN = win_count(IMG_W, IMG_H, K, PAD);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DIN_W-1:0] in_data;
    logic             start;
    logic             frame_loaded;
    logic             busy;
    logic             win_valid;
    logic             win_ready;
    logic [DW-1:0]    win_data;
    logic [RW-1:0]    win_row;
    logic [CW-1:0]    win_col;
    logic             win_last;
    logic [1:0]       dbg_state;

    cnn_window_buffer #(
        .IMG_W (IMG_W), .IMG_H (IMG_H), .K (K), .DIN_W (DIN_W), .PIX_W (PIX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .start        (start),
        .frame_loaded (frame_loaded),
        .busy         (busy),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_row      (win_row),
        .win_col      (win_col),
        .win_last     (win_last),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  img;
    int            checks = 0;
    int            errors = 0;
    int            got_cnt = 0;
    int            hot_cnt = 0;
    logic [DW-1:0] first_data;
    logic [DW-1:0] cap_a;
    logic [DW-1:0] cap_b;
    bit            stalled = 1'b0;
    logic [EW-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] model_win(input int ar, input int ac, input bit last);
        logic [DW-1:0] d;
        int pr;
        int pc;
        logic b;
        d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                pr = ar + r - OFF;
                pc = ac + c - OFF;
                b = (pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W) ? img[pr*IMG_W+pc] : 1'b0;
                d[(r*K+c)*PIX_W +: PIX_W] = {PIX_W{b}};
            end
        end
        return {last, RW'(ar), CW'(ac), d};
    endfunction

    function automatic bit has_hot(input logic [DW-1:0] d);
        for (int e = 0; e < K*K; e++)
            if (d[e*PIX_W +: PIX_W] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] act;
        act = {win_last, win_row, win_col, win_data};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {win_valid, act}, {1'b1, held});
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_window: got %0h expected none", act);
                end else begin
                    chk("window", act, exp_q.pop_front());
                end
                if (got_cnt == 0) first_data = win_data;
                if (int'(win_row) == 0 && int'(win_col) == 0) cap_a = win_data;
                if (int'(win_row) == 14 && int'(win_col) == 14) cap_b = win_data;
                if (has_hot(win_data)) hot_cnt++;
                got_cnt++;
            end
            stalled = win_valid && !win_ready;
            held    = act;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; win_ready = 1'b0; in_data = '0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic load_frame();
        chk("in_ready_load", in_ready, 1'b1);
        for (int b = 0; b < NB; b++) begin
            in_valid = 1'b1;
            in_data  = img[b*DIN_W +: DIN_W];
            if (b == NB - 1) chk("loaded_before_last", frame_loaded, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("frame_loaded", frame_loaded, 1'b1);
        chk("in_ready_full", in_ready, 1'b0);
    endtask

    task automatic run_scan(input bit rnd, input int stop_after);
        int target;
        int cyc;
        target  = (stop_after > 0) ? stop_after : NWIN;
        got_cnt = 0;
        hot_cnt = 0;
        exp_q.delete();
        for (int ar = 0; ar <= RMAX; ar++)
            for (int ac = 0; ac <= CMAX; ac++)
                exp_q.push_back(model_win(ar, ac, (ar == RMAX && ac == CMAX)));
        win_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_t1", busy, 1'b1);
        chk("valid_t1", win_valid, 1'b0);
        @(posedge clk); #1;
        chk("valid_t2", win_valid, 1'b1);
        cyc = 0;
        while (got_cnt < target && cyc < 20000) begin
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (got_cnt < target) chk("scan_timeout", got_cnt, target);
        if (stop_after == 0) begin
            chk("end_valid", win_valid, 1'b0);
            chk("end_busy", busy, 1'b0);
            chk("end_loaded", frame_loaded, 1'b0);
            chk("end_in_ready", in_ready, 1'b1);
            chk("window_count", got_cnt, NWIN);
            chk("queue_empty", exp_q.size(), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset(2);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_loaded", frame_loaded, 1'b0);
        chk("rst_win_last", win_last, 1'b0);
        chk("rst_win_data", win_data, '0);
        chk("rst_row_col", {win_row, win_col}, '0);
        chk("rst_state", dbg_state, ST_LOAD);

        // start outside FULL is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_load", busy, 1'b0);

`ifdef CNN_WIN_ZEROPAD_EN
        img = '1;
        load_frame();
        run_scan(1'b0, 0);
        chk("pad_corner", cap_a, 18'h3CF00);
        chk("pad_centre", cap_b, 18'h3FFFF);
        load_frame();
        run_scan(1'b1, 0);
`else
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r*IMG_W+c] = 1'((r + c) & 1);
        load_frame();
        run_scan(1'b0, 0);
        chk("first_window", first_data, 18'h0CCCC);

        load_frame();
        run_scan(1'b1, 0);

        // single hot pixel; FULL must ignore further input beats
        img = '0;
        img[5*IMG_W+7] = 1'b1;
        load_frame();
        in_valid = 1'b1;
        in_data  = '1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("full_in_ready", in_ready, 1'b0);
        run_scan(1'b0, 0);
        chk("hot_windows", hot_cnt, 9);

        // reset mid-scan
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r*IMG_W+c] = 1'((r + c) & 1);
        load_frame();
        run_scan(1'b0, 100);
        rst = 1'b1;
        win_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", win_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        exp_q.delete();

        // rst and start together: rst wins
        load_frame();
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        chk("rst_start_loaded", frame_loaded, 1'b0);

        load_frame();
        run_scan(1'b1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_window_buffer.md
# cnn_window_buffer

Frame buffer and sliding-window generator for the binary-input CNN front end. It accepts a binarised image as packed multi-pixel beats and stores it as one bit per pixel. It then streams every K×K convolution window to the first conv layer under a valid/ready handshake, with each pixel expanded to PIX_W bits. It replaces the fixed 28×28, 3×3, combinational-read input RAM with a parametrised, registered, flow-controlled block.

## Interface
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 3, window side (odd, ≥1, ≤ IMG_W and ≤ IMG_H)
- DIN_W, 8, pixels per input beat; IMG_W*IMG_H must be a multiple of DIN_W
- PIX_W, 2, output bits per pixel (input bit replicated PIX_W times)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  buffer accepts beats (LOAD state only)
- in_data  in  DIN_W  bit i = pixel at linear address wr_ptr+i (row-major)
- start  in  1  one-cycle pulse: begin scan of loaded frame
- frame_loaded  out  1  full frame stored, scan not finished
- busy  out  1  scan in progress
- win_valid  out  1  window output valid
- win_ready  in  1  consumer accepts window
- win_data  out  K*K*PIX_W  element e = r*K+c in bits [e*PIX_W +: PIX_W]; e=0 top-left, e=K*K-1 bottom-right
- win_row  out  $clog2(IMG_H)  anchor row of the window's top-left element
- win_col  out  $clog2(IMG_W)  anchor column of the window's top-left element
- win_last  out  1  qualifies the final window of the frame

## Operation
- Storage: IMG_W*IMG_H × 1-bit array. Write port writes DIN_W consecutive bits per beat. Read path fetches K*K bits per cycle.
- FSM states and transitions:
  - LOAD → FULL on the final accepted beat, when wr_ptr + DIN_W == IMG_W*IMG_H.
  - FULL → SCAN on start.
  - SCAN → LOAD when the last window handshakes.
- LOAD:
  - in_ready=1; each in_valid&&in_ready writes in_data and advances wr_ptr by DIN_W.
  - wr_ptr resets to 0 on entry.
- FULL:
  - frame_loaded=1, in_ready=0; in_data is ignored.
- SCAN:
  - busy=1, frame_loaded=1.
  - Anchors are visited row-major, row 0..IMG_H-K, col 0..IMG_W-K: (IMG_W-K+1)*(IMG_H-K+1) windows, 676 at defaults.
- start outside FULL is ignored. in_valid outside LOAD is ignored and never written.
- Output stage is a one-entry skid register:
  - A new window is loaded when the register is empty or win_valid&&win_ready.
  - While win_valid&&!win_ready, win_data, win_row, win_col and win_last hold stable.
- Expansion: stored bit b → {PIX_W{b}}.
- Reset: state=LOAD, wr_ptr=0, scan counters=0.
  - Outputs after reset: in_ready=1; frame_loaded, busy, win_valid, win_last=0; win_data, win_row, win_col=0.
  - Array contents are not cleared.
- Reset mid-load or mid-scan discards all progress. The pending window is dropped.

## Timing
- Last input beat accepted at cycle t → frame_loaded=1 at t+1.
- start sampled at cycle t → busy=1 at t+1, first win_valid at t+2. One-cycle read/address latency.
- With win_ready held high, throughput is one window per cycle, no bubbles.
- Last window handshaked at cycle t → at t+1: win_valid=0, busy=0, frame_loaded=0, in_ready=1.
- Simultaneous start and rst: rst wins.
- win_last rises together with win_valid for the final anchor only.

## Configuration
- CNN_WIN_ZEROPAD_EN defined: "same" padding.
  - All IMG_W*IMG_H anchors are scanned, centre-anchored; win_row/win_col give the centre pixel.
  - Elements outside the image read as 0.
  - Requires odd K.
- CNN_WIN_ZEROPAD_EN undefined: valid-only scan as above; no boundary muxing is synthesised.

## Structure
- Shared package cnn_pkg holds:
  - FSM state enum (ST_LOAD, ST_FULL, ST_SCAN)
  - default image/kernel constants
  - window-count and address-width helper functions
- Sub-module cnn_win_scan:
  - anchor row/col counters
  - K*K read-address generation
  - padding mask when CNN_WIN_ZEROPAD_EN is defined
  - last-window detection
- The top level holds the storage array, write packer, FSM and output skid register.

## Test plan
- Reset: assert rst 2 cycles → in_ready=1; win_valid, busy, frame_loaded, win_last=0; win_data=0.
- Checkerboard pixel(r,c)=(r+c)&1, 98 beats → frame_loaded=1 the cycle after beat 98.
  - Then start → 676 windows, first at start+2.
  - Window (0,0) = elements {0,3,0,3,0,3,0,3,0}.
  - win_last only on (25,25).
- Backpressure: win_ready pseudo-random 50% → held data stable while stalled; 676 windows in order, none lost or duplicated.
- Single hot pixel at (5,7) → exactly the 9 windows with anchors rows 3..5, cols 5..7 contain a 2'b11.
  - In each, the 2'b11 is at element (5-row)*3+(7-col); all other elements are 0.
- rst after 100 windows → next cycle: win_valid=0, busy=0, in_ready=1; a new load + scan yields 676 windows again.
- CNN_WIN_ZEROPAD_EN, all-ones frame → 784 windows.
  - Centre (0,0) window has elements 0,1,2,3,6 = 0 and the rest = 2'b11.
  - Centre (14,14) window is all 2'b11.
